// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM timebase: state encoding, field widths and
// the prescaler terminal-count helper.
package pwm_pkg;

  localparam int PRESCALER_W = 7;
  localparam int DIV_W       = 3;

  typedef enum logic [1:0] {
    TB_DISABLED  = 2'd0,
    TB_INTERNAL  = 2'd1,
    TB_EXTERNAL  = 2'd2,
    TB_EXT_FAULT = 2'd3
  } tb_state_t;

  // Terminal prescaler value for a divisor exponent: 2^div - 1.
  function automatic logic [PRESCALER_W-1:0] period_max(input logic [DIV_W-1:0] div);
    logic [PRESCALER_W:0] span;
    span = (PRESCALER_W + 1)'(1) << div;
    return PRESCALER_W'(span - (PRESCALER_W + 1)'(1));
  endfunction

endpackage

// File: rtl/pwm_tb_ext_conditioner.sv
// External timebase conditioning: 2-flop synchroniser, optional glitch filter
// (PWM_TB_EXT_FILTER_EN) and rising-edge detector producing a 1-cycle pulse.
module pwm_tb_ext_conditioner
`ifdef PWM_TB_EXT_FILTER_EN
#(
  parameter int FILTER_DEPTH = 3
)
`endif
(
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic level;
  logic level_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

`ifdef PWM_TB_EXT_FILTER_EN
  localparam int CW = (FILTER_DEPTH > 1) ? $clog2(FILTER_DEPTH) : 1;

  logic [CW-1:0] run_cnt;
  logic          flt_level;

  // The filtered level follows sync2 only after FILTER_DEPTH samples that all
  // differ from the current level; any agreeing sample restarts the run.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_cnt   <= '0;
      flt_level <= 1'b0;
    end else if (sync2 == flt_level) begin
      run_cnt <= '0;
    end else if (run_cnt == CW'(FILTER_DEPTH - 1)) begin
      run_cnt   <= '0;
      flt_level <= sync2;
    end else begin
      run_cnt <= run_cnt + CW'(1);
    end
  end

  assign level = flt_level;
`else
  assign level = sync2;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) level_q <= 1'b0;
    else       level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/pwm_timebase_generator.sv
// PWM timebase: power-of-two internal prescaler or synchronised external
// timebase with loss-of-edge fault. Build option PWM_TB_EXT_FILTER_EN.
module pwm_timebase_generator
  import pwm_pkg::*;
#(
  parameter int EXT_TIMEOUT = 1024
`ifdef PWM_TB_EXT_FILTER_EN
  ,
  parameter int FILTER_DEPTH = 3
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             external_enable,
  input  logic [DIV_W-1:0] divider_setting,
  input  logic             sync,
  input  logic             external_timebase,
  output logic             timebase_out,
  output logic             timebase_active,
  output logic             ext_fault,
  output logic [1:0]       state_dbg
);

  localparam int TW = $clog2(EXT_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(EXT_TIMEOUT);

  tb_state_t              state;
  tb_state_t              next_state;
  logic [DIV_W-1:0]       div_q;
  logic [PRESCALER_W-1:0] prescaler;
  logic [TW-1:0]          timeout;
  logic                   ext_rise;
  logic                   wrap;
  logic                   state_change;
  logic                   tick_d;

  pwm_tb_ext_conditioner
`ifdef PWM_TB_EXT_FILTER_EN
  #(
    .FILTER_DEPTH(FILTER_DEPTH)
  )
`endif
  u_ext_cond (
    .clock (clock),
    .reset (reset),
    .pin   (external_timebase),
    .rise  (ext_rise)
  );

  assign wrap         = (prescaler == period_max(div_q));
  assign state_change = (next_state != state);
  assign state_dbg    = state;

  always_comb begin
    next_state = state;
    if (!enable) begin
      next_state = TB_DISABLED;
    end else if (!external_enable) begin
      next_state = TB_INTERNAL;
    end else begin
      case (state)
        TB_DISABLED, TB_INTERNAL: next_state = TB_EXTERNAL;
        TB_EXTERNAL: if (timeout == TIMEOUT_MAX) next_state = TB_EXT_FAULT;
        default: next_state = state;
      endcase
    end
  end

  // Ticks are only issued from a state that persists, so a tick never lands
  // in DISABLED or EXT_FAULT after a transition. sync outranks a wrap.
  always_comb begin
    tick_d = 1'b0;
    if (!state_change) begin
      case (state)
        TB_INTERNAL: tick_d = wrap && !sync;
        TB_EXTERNAL: tick_d = ext_rise;
        default:     tick_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= TB_DISABLED;
      timebase_out    <= 1'b0;
      timebase_active <= 1'b0;
      ext_fault       <= 1'b0;
    end else begin
      state           <= next_state;
      timebase_out    <= tick_d;
      timebase_active <= (next_state == TB_INTERNAL) || (next_state == TB_EXTERNAL);
      ext_fault       <= (next_state == TB_EXT_FAULT);
    end
  end

  // Shadow divisor: changes of divider_setting take effect only at a period boundary.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else if (next_state == TB_INTERNAL &&
                 (state != TB_INTERNAL || sync || wrap)) begin
      div_q <= divider_setting;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
    end else if (state_change || state != TB_INTERNAL) begin
      prescaler <= '0;
    end else if (sync || wrap) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PRESCALER_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timeout <= '0;
    end else if (state_change || state != TB_EXTERNAL) begin
      timeout <= '0;
    end else if (sync || ext_rise) begin
      timeout <= '0;
    end else if (timeout != TIMEOUT_MAX) begin
      timeout <= timeout + TW'(1);
    end
  end

endmodule

// File: tb/tb_pwm_timebase_generator.sv
// Directed bench for pwm_timebase_generator: per-cycle vector table for the
// internal divider, hand-written sequences for external mode, sync and reset.
module tb_pwm_timebase_generator;
  import pwm_pkg::*;

`ifdef PWM_TB_EXT_FILTER_EN
  localparam int EXT_LAT = 6;
`else
  localparam int EXT_LAT = 3;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       external_enable = 1'b0;
  logic [2:0] divider_setting = 3'd0;
  logic       sync = 1'b0;
  logic       external_timebase = 1'b0;
  logic       timebase_out;
  logic       timebase_active;
  logic       ext_fault;
  logic [1:0] state_dbg;

  pwm_timebase_generator #(
    .EXT_TIMEOUT(16)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .enable            (enable),
    .external_enable   (external_enable),
    .divider_setting   (divider_setting),
    .sync              (sync),
    .external_timebase (external_timebase),
    .timebase_out      (timebase_out),
    .timebase_active   (timebase_active),
    .ext_fault         (ext_fault),
    .state_dbg         (state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  typedef struct {
    logic       en;
    logic       ext;
    logic [2:0] div;
    logic       exp_out;
    logic       exp_act;
    logic       exp_flt;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic add_vec(input logic en, input logic ext, input logic [2:0] div,
                         input logic eo, input logic ea, input logic ef);
    vecs.push_back('{en, ext, div, eo, ea, ef});
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick_edge();
    @(posedge clock);
    #1;
  endtask

  // Edges until timebase_out is seen high (inclusive); -1 if limit expires.
  task automatic wait_tick(input int limit, output int edges);
    edges = -1;
    for (int i = 1; i <= limit; i++) begin
      tick_edge();
      if (timebase_out) begin
        edges = i;
        break;
      end
    end
  endtask

  initial begin
    int e;
    int ticks;
    int lat;

    // reset state
    reset = 1'b1;
    tick_edge();
    tick_edge();
    check("reset timebase_out", timebase_out, 0);
    check("reset timebase_active", timebase_active, 0);
    check("reset ext_fault", ext_fault, 0);
    check("reset state", state_dbg, int'(TB_DISABLED));
    @(negedge clock);
    reset = 1'b0;

    // Internal div=3 from entry: ticks 8 and 16 edges after the entry edge (row 0).
    for (int i = 0; i <= 16; i++) add_vec(1'b1, 1'b0, 3'd3, (i == 8 || i == 16), 1'b1, 1'b0);
    // div->0 mid-period: period in flight stays 8 (tick row 24), then every cycle.
    for (int i = 17; i <= 27; i++) add_vec(1'b1, 1'b0, 3'd0, (i >= 24), 1'b1, 1'b0);
    add_vec(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    // div=0 entry: first tick one cycle after entry.
    add_vec(1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    add_vec(1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    add_vec(1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    // INTERNAL -> EXTERNAL: no tick on the transition, pin low.
    add_vec(1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0);
    add_vec(1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      enable          = vecs[i].en;
      external_enable = vecs[i].ext;
      divider_setting = vecs[i].div;
      tick_edge();
      check($sformatf("vec%0d timebase_out", i), timebase_out, int'(vecs[i].exp_out));
      check($sformatf("vec%0d timebase_active", i), timebase_active, int'(vecs[i].exp_act));
      check($sformatf("vec%0d ext_fault", i), ext_fault, int'(vecs[i].exp_flt));
    end
    check("external state", state_dbg, int'(TB_EXTERNAL));

    // External pin, period 20: one tick per rise at fixed latency.
    // A sync in the low phase keeps the timeout counter from expiring.
    for (int r = 0; r < 3; r++) begin
      external_timebase = 1'b1;
      ticks = 0;
      lat = -1;
      for (int k = 1; k <= 10; k++) begin
        tick_edge();
        if (timebase_out) begin
          ticks++;
          lat = k;
        end
      end
      check($sformatf("ext rise%0d tick count", r), ticks, 1);
      check($sformatf("ext rise%0d latency", r), lat, EXT_LAT);
      external_timebase = 1'b0;
      ticks = 0;
      for (int k = 1; k <= 10; k++) begin
        sync = (k == 3);
        tick_edge();
        if (timebase_out) ticks++;
      end
      sync = 1'b0;
      check($sformatf("ext fall%0d tick count", r), ticks, 0);
      check($sformatf("ext period%0d ext_fault", r), ext_fault, 0);
      check($sformatf("ext period%0d active", r), timebase_active, 1);
    end

    // Two-cycle pulse on the pin.
    external_timebase = 1'b1;
    sync = 1'b1;
    tick_edge();
    sync = 1'b0;
    tick_edge();
    external_timebase = 1'b0;
    ticks = 0;
    for (int k = 1; k <= 7; k++) begin
      tick_edge();
      if (timebase_out) ticks++;
    end
`ifdef PWM_TB_EXT_FILTER_EN
    check("glitch filtered tick count", ticks, 0);
`else
    check("short pulse tick count", ticks, 1);
`endif

    // Timeout: fresh EXTERNAL entry with pin low, fault 17 cycles after entry.
    enable = 1'b0;
    external_enable = 1'b0;
    tick_edge();
    check("disable state", state_dbg, int'(TB_DISABLED));
    enable = 1'b1;
    external_enable = 1'b1;
    for (int k = 1; k <= 17; k++) tick_edge();
    check("timeout pre ext_fault", ext_fault, 0);
    check("timeout pre active", timebase_active, 1);
    tick_edge();
    check("timeout ext_fault", ext_fault, 1);
    check("timeout active", timebase_active, 0);
    check("timeout state", state_dbg, int'(TB_EXT_FAULT));
    external_timebase = 1'b1;
    ticks = 0;
    for (int k = 1; k <= 8; k++) begin
      tick_edge();
      if (timebase_out) ticks++;
    end
    external_timebase = 1'b0;
    check("fault no ticks", ticks, 0);
    check("fault held", ext_fault, 1);

    // Leave fault to INTERNAL at div=3; first tick 8 edges after entry.
    divider_setting = 3'd3;
    external_enable = 1'b0;
    tick_edge();
    check("recover ext_fault", ext_fault, 0);
    check("recover active", timebase_active, 1);
    check("recover state", state_dbg, int'(TB_INTERNAL));
    wait_tick(20, e);
    check("recover first tick", e, 8);

    // sync sampled 5 edges after a tick: tick at +8 suppressed, next 8 after sync.
    for (int k = 1; k <= 4; k++) tick_edge();
    sync = 1'b1;
    tick_edge();
    check("sync edge no tick", timebase_out, 0);
    sync = 1'b0;
    wait_tick(20, e);
    check("sync restart interval", e, 8);

    // div 3->5 two edges into a period: current period stays 8, then 32.
    tick_edge();
    tick_edge();
    divider_setting = 3'd5;
    wait_tick(20, e);
    check("div change current period", e, 6);
    wait_tick(50, e);
    check("div change new period a", e, 32);
    wait_tick(50, e);
    check("div change new period b", e, 32);

    // sync coincident with the wrap: no tick, period restarts.
    for (int k = 1; k <= 31; k++) tick_edge();
    sync = 1'b1;
    tick_edge();
    check("sync beats wrap", timebase_out, 0);
    sync = 1'b0;
    divider_setting = 3'd7;
    wait_tick(50, e);
    check("post sync period", e, 32);
    wait_tick(200, e);
    check("div7 period", e, 128);
    divider_setting = 3'd0;
    wait_tick(200, e);
    check("div7 last period", e, 128);
    wait_tick(5, e);
    check("div0 period a", e, 1);
    wait_tick(5, e);
    check("div0 period b", e, 1);

    // Reset mid-period, then resume.
    divider_setting = 3'd3;
    wait_tick(5, e);
    check("div3 reload", e, 1);
    wait_tick(20, e);
    check("div3 period", e, 8);
    tick_edge();
    tick_edge();
    tick_edge();
    #2;
    reset = 1'b1;
    #1;
    check("async reset active", timebase_active, 0);
    check("async reset out", timebase_out, 0);
    check("async reset state", state_dbg, int'(TB_DISABLED));
    tick_edge();
    tick_edge();
    check("held reset out", timebase_out, 0);
    @(negedge clock);
    reset = 1'b0;
    // First edge after release enters INTERNAL; tick 8 edges later.
    wait_tick(20, e);
    check("post reset first tick", e, 9);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule
